yarp_mem_arbiter: RTL and testbench

- Sits directly downstream of the core's instruction cache (cache_top) and data cache (d_cache_top).
- Arbitrates their line-refill reads and data-cache line writebacks onto a single shared word-wide backing-memory port.
- Each granted transaction is a burst of LINE_WORDS word beats to consecutive word addresses, with an outstanding-read counter and round-robin fairness.
- Clock `clk`; reset `reset` is synchronous and active-high.

---
 rtl/yarp_pkg.sv | 31 +++
 rtl/yarp_rr_arbiter2.sv | 35 +++
 rtl/yarp_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_yarp_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yarp_pkg.sv
// -----------------------------------------------------------------------------
// yarp_pkg
//
// Shared types and constants for the YARP memory-side blocks.
//
// Contents:
//   YARP_LINE_WORDS : default number of word beats in one cache line burst
//   arb_state_e     : memory arbiter FSM state (IDLE / ISSUE / WAIT)
//   arb_owner_e     : which cache owns the shared memory port (OWN_IC / OWN_DC)
//   other_owner()   : the owner that is not the given one (round-robin helper)
// -----------------------------------------------------------------------------
package yarp_pkg;

    localparam int YARP_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } arb_owner_e;

    function automatic arb_owner_e other_owner(input arb_owner_e owner);
        return (owner == OWN_IC) ? OWN_DC : OWN_IC;
    endfunction

endpackage

// File: rtl/yarp_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// yarp_rr_arbiter2
//
// Combinational two-way round-robin picker for the I-cache / D-cache requests.
// A lone request always wins; on a tie the requester that did not own the
// previous burst wins.
//
// Ports:
//   ic_req     in   I-cache request
//   dc_req     in   D-cache request
//   last_owner in   owner of the most recently completed burst
//   gnt_valid  out  at least one request is present
//   gnt_owner  out  selected owner (meaningful only when gnt_valid = 1)
// -----------------------------------------------------------------------------
module yarp_rr_arbiter2
    import yarp_pkg::*;
(
    input  logic       ic_req,
    input  logic       dc_req,
    input  arb_owner_e last_owner,
    output logic       gnt_valid,
    output arb_owner_e gnt_owner
);

    always_comb begin
        gnt_valid = ic_req | dc_req;
        gnt_owner = OWN_IC;
        if (ic_req && dc_req) begin
            gnt_owner = other_owner(last_owner);
        end else if (dc_req) begin
            gnt_owner = OWN_DC;
        end
    end

endmodule

// File: rtl/yarp_mem_arbiter.sv
// -----------------------------------------------------------------------------
// yarp_mem_arbiter
//
// Shares one word-wide backing-memory port between the instruction cache and
// the data cache. Each granted transaction is a burst of LINE_WORDS beats to
// consecutive word addresses: I-cache refills are always reads, D-cache bursts
// are refills or writebacks depending on dc_we_i at grant time. Read responses
// return in order and may overlap the issue phase.
//
// Handshake summary (one place for the whole block):
//   cache side : *_req_i is held high until *_done_o. *_gnt_o pulses for one
//                cycle on the first issue cycle of the burst. *_rvalid_o marks
//                a read beat on *_rdata_o. *_done_o pulses with the last read
//                beat, or with the acceptance of the last write beat.
//   memory side: a beat transfers in every cycle where mem_req_o and
//                mem_gnt_i are both high; mem_addr_o/mem_we_o/mem_wdata_o are
//                stable while mem_req_o is high and not yet granted.
//                mem_rvalid_i carries one in-order read response per cycle and
//                has no back-pressure.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   ic_req_i, ic_addr_i  I-cache refill request and line address
//   ic_gnt_o             I-cache burst started (1-cycle pulse)
//   ic_rvalid_o/rdata_o  I-cache read beat
//   ic_done_o            I-cache burst complete (1-cycle pulse)
//   dc_req_i, dc_we_i    D-cache request; 1 = writeback, 0 = refill
//   dc_addr_i            D-cache line address
//   dc_wbeat_o           beat index of the write word being requested
//   dc_wdata_i           write word for dc_wbeat_o (combinational from cache)
//   dc_gnt_o/rvalid_o/rdata_o/done_o   as for the I-cache
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o   beat request to memory
//   mem_gnt_i            memory accepted the current beat
//   mem_rvalid_i/rdata_i in-order read response
//   dbg_state            current FSM state, for observation only
// -----------------------------------------------------------------------------
module yarp_mem_arbiter
    import yarp_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = YARP_LINE_WORDS
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          ic_req_i,
    input  logic [ADDR_W-1:0]             ic_addr_i,
    output logic                          ic_gnt_o,
    output logic                          ic_rvalid_o,
    output logic [DATA_W-1:0]             ic_rdata_o,
    output logic                          ic_done_o,

    input  logic                          dc_req_i,
    input  logic                          dc_we_i,
    input  logic [ADDR_W-1:0]             dc_addr_i,
    output logic [$clog2(LINE_WORDS)-1:0] dc_wbeat_o,
    input  logic [DATA_W-1:0]             dc_wdata_i,
    output logic                          dc_gnt_o,
    output logic                          dc_rvalid_o,
    output logic [DATA_W-1:0]             dc_rdata_o,
    output logic                          dc_done_o,

    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    input  logic                          mem_gnt_i,
    input  logic                          mem_rvalid_i,
    input  logic [DATA_W-1:0]             mem_rdata_i,

    output arb_state_e                    dbg_state
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    // One extra bit so a counter can hold LINE_WORDS itself.
    localparam int CNT_W  = BEAT_W + 1;
    // Byte offset inside a line: word-in-line bits plus the 2 byte bits.
    localparam int OFF_W  = BEAT_W + 2;

    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    arb_owner_e        last_owner_q, last_owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  resp_cnt_q, resp_cnt_d;
    // High only on the first ISSUE cycle of a burst; drives the gnt pulse.
    logic              first_q, first_d;

    // Owner-independent burst events, routed to the owning cache below.
    logic              burst_gnt;
    logic              burst_rvalid;
    logic              burst_done;

    logic              arb_valid;
    arb_owner_e        arb_owner;

    yarp_rr_arbiter2 u_rr (
        .ic_req     (ic_req_i),
        .dc_req     (dc_req_i),
        .last_owner (last_owner_q),
        .gnt_valid  (arb_valid),
        .gnt_owner  (arb_owner)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IC;
            last_owner_q <= OWN_IC;
            we_q         <= 1'b0;
            base_q       <= '0;
            issue_cnt_q  <= '0;
            resp_cnt_q   <= '0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            base_q       <= base_d;
            issue_cnt_q  <= issue_cnt_d;
            resp_cnt_q   <= resp_cnt_d;
            first_q      <= first_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and memory-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        base_d       = base_q;
        issue_cnt_d  = issue_cnt_q;
        resp_cnt_d   = resp_cnt_q;
        first_d      = 1'b0;

        burst_gnt    = 1'b0;
        burst_rvalid = 1'b0;
        burst_done   = 1'b0;

        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        dc_wbeat_o   = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    owner_d     = arb_owner;
                    // The I-cache never writes, so its bursts are always reads.
                    we_d        = (arb_owner == OWN_DC) ? dc_we_i : 1'b0;
                    base_d      = ((arb_owner == OWN_DC) ? dc_addr_i : ic_addr_i) & ~OFF_MASK;
                    issue_cnt_d = '0;
                    resp_cnt_d  = '0;
                    first_d     = 1'b1;
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                burst_gnt   = first_q;
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = base_q + (ADDR_W'(issue_cnt_q) << 2);
                mem_wdata_o = dc_wdata_i;
                if (owner_q == OWN_DC) begin
                    dc_wbeat_o = issue_cnt_q[BEAT_W-1:0];
                end

                if (mem_gnt_i) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == LAST_BEAT) begin
                        if (we_q) begin
                            // Writebacks finish as soon as the last beat is taken.
                            burst_done   = 1'b1;
                            last_owner_d = owner_q;
                            state_d      = IDLE;
                        end else begin
                            // May be overridden to IDLE below if the final
                            // response lands in this same cycle.
                            state_d = WAIT;
                        end
                    end
                end
            end

            WAIT: begin
                // Nothing left to issue; only responses are collected.
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Read response path, live in ISSUE and WAIT. Responses arriving in
        // IDLE belong to an abandoned burst and are dropped.
        if ((state_q == ISSUE || state_q == WAIT) && !we_q && mem_rvalid_i) begin
            burst_rvalid = 1'b1;
            resp_cnt_d   = resp_cnt_q + 1'b1;
            if (resp_cnt_q == LAST_BEAT) begin
                burst_done   = 1'b1;
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Cache-side routing
    // ------------------------------------------------------------------
    always_comb begin
        ic_gnt_o    = burst_gnt    && (owner_q == OWN_IC);
        ic_rvalid_o = burst_rvalid && (owner_q == OWN_IC);
        ic_done_o   = burst_done   && (owner_q == OWN_IC);
        dc_gnt_o    = burst_gnt    && (owner_q == OWN_DC);
        dc_rvalid_o = burst_rvalid && (owner_q == OWN_DC);
        dc_done_o   = burst_done   && (owner_q == OWN_DC);
        // Read data is only driven for the owner's valid beats so idle
        // outputs stay at zero.
        ic_rdata_o  = ic_rvalid_o ? mem_rdata_i : '0;
        dc_rdata_o  = dc_rvalid_o ? mem_rdata_i : '0;
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_yarp_mem_arbiter
//
// Directed bench for yarp_mem_arbiter. Stimulus pushes the expected grants,
// memory beats, read beats and done pulses into per-kind queues; a monitor
// pops and compares them whenever the DUT presents the matching output.
// A small memory model answers reads in order after a programmable latency.
// -----------------------------------------------------------------------------
module tb_yarp_mem_arbiter;
  import yarp_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int DRAIN_CYC = 120;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          ic_req_i = 1'b0;
  logic [AW-1:0] ic_addr_i = '0;
  logic          ic_gnt_o, ic_rvalid_o, ic_done_o;
  logic [DW-1:0] ic_rdata_o;
  logic          dc_req_i = 1'b0;
  logic          dc_we_i = 1'b0;
  logic [AW-1:0] dc_addr_i = '0;
  logic [1:0]    dc_wbeat_o;
  logic [DW-1:0] dc_wdata_i;
  logic          dc_gnt_o, dc_rvalid_o, dc_done_o;
  logic [DW-1:0] dc_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  arb_state_e    dbg_state;

  yarp_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .ic_req_i     (ic_req_i),
    .ic_addr_i    (ic_addr_i),
    .ic_gnt_o     (ic_gnt_o),
    .ic_rvalid_o  (ic_rvalid_o),
    .ic_rdata_o   (ic_rdata_o),
    .ic_done_o    (ic_done_o),
    .dc_req_i     (dc_req_i),
    .dc_we_i      (dc_we_i),
    .dc_addr_i    (dc_addr_i),
    .dc_wbeat_o   (dc_wbeat_o),
    .dc_wdata_i   (dc_wdata_i),
    .dc_gnt_o     (dc_gnt_o),
    .dc_rvalid_o  (dc_rvalid_o),
    .dc_rdata_o   (dc_rdata_o),
    .dc_done_o    (dc_done_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [0:0]  gnt_q[$];   // owner: 0 = IC, 1 = DC
  logic [64:0] beat_q[$];  // {we, addr, wdata}
  logic [32:0] rv_q[$];    // {port, data}
  logic [0:0]  done_q[$];  // owner
  int total = 0;
  int bad = 0;

  // ---------------- environment knobs ----------------
  int          ic_wants = 0;
  int          dc_wants = 0;
  int          gnt_mode = 0;      // 0 always, 1 alternate cycles, 2 never
  int          lat = 1;           // read response latency in cycles
  int          cyc = 0;
  logic [31:0] rd_base = '0;
  logic [31:0] wbase = '0;
  int          rsp_due_q[$];
  logic [31:0] rsp_dat_q[$];

  // D-cache write-data model: word depends only on the requested beat.
  always_comb dc_wdata_i = wbase + 32'(dc_wbeat_o);

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [64:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  task automatic pop_gnt(input logic [0:0] act);
    if (gnt_q.size() == 0) unexpected("gnt", act);
    else check("gnt_owner", act, gnt_q.pop_front());
  endtask

  task automatic pop_beat(input logic [64:0] act);
    logic [64:0] e;
    if (beat_q.size() == 0) unexpected("mem_beat", act);
    else begin
      e = beat_q.pop_front();
      check("beat_we_addr", act[64:32], e[64:32]);
      if (e[64]) check("beat_wdata", act[31:0], e[31:0]);
    end
  endtask

  task automatic pop_rv(input logic [32:0] act);
    if (rv_q.size() == 0) unexpected("rvalid", act);
    else check("rvalid_port_data", act, rv_q.pop_front());
  endtask

  task automatic pop_done(input logic [0:0] act);
    if (done_q.size() == 0) unexpected("done", act);
    else check("done_owner", act, done_q.pop_front());
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctrl"}, {ic_gnt_o, ic_rvalid_o, ic_done_o, dc_gnt_o, dc_rvalid_o,
                           dc_done_o, dc_wbeat_o, mem_req_o, mem_we_o}, 65'h0);
    check({tag, "_ic_rdata"}, ic_rdata_o, 65'h0);
    check({tag, "_dc_rdata"}, dc_rdata_o, 65'h0);
    check({tag, "_mem_addr"}, mem_addr_o, 65'h0);
    check({tag, "_mem_wdata"}, mem_wdata_o, 65'h0);
    check({tag, "_state"}, dbg_state, IDLE);
  endtask

  // which: 0 ic_gnt, 1 dc_gnt, 2 ic_done, 3 dc_done. n = negedges waited.
  task automatic wait_for(input string name, input int which, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < DRAIN_CYC) begin
      @(negedge clk);
      n++;
      case (which)
        0: hit = ic_gnt_o;
        1: hit = dc_gnt_o;
        2: hit = ic_done_o;
        default: hit = dc_done_o;
      endcase
    end
    if (!hit) begin
      unexpected({name, "_timeout"}, 65'(n));
      n = -1;
    end
  endtask

  task automatic drain(input string name);
    int left;
    for (int i = 0; i < DRAIN_CYC; i++) begin
      if (gnt_q.size() + beat_q.size() + rv_q.size() + done_q.size() == 0) break;
      @(negedge clk);
    end
    left = gnt_q.size() + beat_q.size() + rv_q.size() + done_q.size();
    check({name, "_leftover"}, 65'(left), 65'h0);
    gnt_q.delete();
    beat_q.delete();
    rv_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_read(input logic owner, input logic [31:0] base, input logic [31:0] dbase);
    gnt_q.push_back(owner);
    for (int i = 0; i < LW; i++) begin
      beat_q.push_back({1'b0, base + 32'(4 * i), 32'h0});
      rv_q.push_back({owner, dbase + 32'(i)});
    end
    done_q.push_back(owner);
  endtask

  task automatic expect_write(input logic [31:0] base, input logic [31:0] dbase);
    gnt_q.push_back(1'b1);
    for (int i = 0; i < LW; i++) begin
      beat_q.push_back({1'b1, base + 32'(4 * i), dbase + 32'(i)});
    end
    done_q.push_back(1'b1);
  endtask

  // ---------------- driver: cache requesters ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ic_req_i = (ic_wants > 0);
      dc_req_i = (dc_wants > 0);
      @(negedge clk);
      if (ic_done_o && ic_wants > 0) ic_wants--;
      if (dc_done_o && dc_wants > 0) dc_wants--;
    end
  end

  // ---------------- driver: backing memory ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (gnt_mode)
        0: mem_gnt_i = 1'b1;
        1: mem_gnt_i = cyc[0];
        default: mem_gnt_i = 1'b0;
      endcase
      if (rsp_due_q.size() > 0 && rsp_due_q[0] <= cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i = rsp_dat_q.pop_front();
        void'(rsp_due_q.pop_front());
      end else begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i = 32'h5A5A_5A5A;
      end
      @(negedge clk);
      if (!reset && mem_req_o && mem_gnt_i && !mem_we_o) begin
        rsp_dat_q.push_back(rd_base + 32'(mem_addr_o[3:2]));
        rsp_due_q.push_back(cyc + lat);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (ic_gnt_o && dc_gnt_o) check("gnt_overlap", 65'h1, 65'h0);
        if (ic_gnt_o) pop_gnt(1'b0);
        if (dc_gnt_o) pop_gnt(1'b1);
        if (mem_req_o && mem_gnt_i) pop_beat({mem_we_o, mem_addr_o, mem_wdata_o});
        if (ic_rvalid_o) pop_rv({1'b0, ic_rdata_o});
        if (dc_rvalid_o) pop_rv({1'b1, dc_rdata_o});
        if (ic_done_o) begin
          pop_done(1'b0);
          check("ic_done_align", ic_rvalid_o, 65'h1);
        end
        if (dc_done_o) begin
          pop_done(1'b1);
          check("dc_done_align", dc_rvalid_o || (mem_req_o && mem_gnt_i && mem_we_o), 65'h1);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;

    // Reset and idle outputs
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst");

    // 1: I-cache only, zero-wait memory, unaligned line address
    lat = 1;
    gnt_mode = 0;
    rd_base = 32'hA0;
    expect_read(1'b0, 32'h0000_1000, 32'hA0);
    @(negedge clk);
    ic_addr_i = 32'h0000_100C;
    ic_wants = 1;
    wait_for("t1_gnt", 0, n);
    check("t1_gnt_latency", 65'(n), 65'd2);
    wait_for("t1_done", 2, n);
    check("t1_done_latency", 65'(n), 65'd4);
    drain("t1");

    // 2: simultaneous requests, D-cache wants two bursts -> DC, IC, DC
    rd_base = 32'hC0;
    expect_read(1'b1, 32'h0000_6000, 32'hC0);
    expect_read(1'b0, 32'h0000_7000, 32'hC0);
    expect_read(1'b1, 32'h0000_6000, 32'hC0);
    @(negedge clk);
    ic_addr_i = 32'h0000_7000;
    dc_addr_i = 32'h0000_6000;
    dc_we_i = 1'b0;
    ic_wants = 1;
    dc_wants = 2;
    drain("t2");

    // 3: D-cache writeback with memory stalling every other cycle
    gnt_mode = 1;
    wbase = 32'hD0;
    expect_write(32'h0000_2000, 32'hD0);
    @(negedge clk);
    dc_addr_i = 32'h0000_2004;
    dc_we_i = 1'b1;
    dc_wants = 1;
    drain("t3");
    check("t3_no_read_resp", 65'(rsp_dat_q.size()), 65'h0);

    // 3b: zero-wait writeback timing
    gnt_mode = 0;
    wbase = 32'hE0;
    expect_write(32'h0000_8000, 32'hE0);
    @(negedge clk);
    dc_addr_i = 32'h0000_8000;
    dc_we_i = 1'b1;
    dc_wants = 1;
    wait_for("t3b_gnt", 1, n);
    wait_for("t3b_done", 3, n);
    check("t3b_done_latency", 65'(n), 65'd3);
    drain("t3b");

    // 4: read with 3-cycle response latency, all beats issue back to back
    lat = 3;
    rd_base = 32'hB0;
    expect_read(1'b0, 32'h0000_5000, 32'hB0);
    @(negedge clk);
    dc_we_i = 1'b0;
    ic_addr_i = 32'h0000_5008;
    ic_wants = 1;
    wait_for("t4_gnt", 0, n);
    wait_for("t4_done", 2, n);
    check("t4_done_latency", 65'(n), 65'd6);
    drain("t4");

    // 5: reset after two beats of an I-cache read, stray responses follow
    rd_base = 32'h90;
    gnt_q.push_back(1'b0);
    beat_q.push_back({1'b0, 32'h0000_3000, 32'h0});
    beat_q.push_back({1'b0, 32'h0000_3004, 32'h0});
    @(negedge clk);
    ic_addr_i = 32'h0000_3000;
    ic_wants = 1;
    wait_for("t5_gnt", 0, n);
    @(negedge clk);
    gnt_mode = 2;
    ic_wants = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t5_stray_rvalid_present", mem_rvalid_i, 65'h1);
    check_idle_outputs("t5_after_rst");
    repeat (4) @(negedge clk);
    drain("t5");
    check("t5_stray_consumed", 65'(rsp_dat_q.size()), 65'h0);

    // 5b: fresh D-cache refill after the abandoned burst
    lat = 1;
    gnt_mode = 0;
    rd_base = 32'hF0;
    expect_read(1'b1, 32'h0000_9000, 32'hF0);
    @(negedge clk);
    dc_addr_i = 32'h0000_9000;
    dc_we_i = 1'b0;
    dc_wants = 1;
    drain("t5b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
